ram_arbiter: RTL

Two-requester arbiter and sequencer for the 32x8 single-port RAM. Accepts read/write commands from requesters A and B, grants at most one per cycle with round-robin fairness and bounded bursts, and drives the RAM's shared data, address and write-enable port. Returns read data with a registered valid strobe routed to the requester that issued the read. Sits between the two bus masters and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_if.sv | 42 ++++
 rtl/ram_arb_rr.sv | 81 ++++++++
 rtl/ram_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default geometry,
// grant-owner encoding and the out-of-range address compare.
package ram_arb_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_AW    = 6;
  localparam int unsigned DEF_DEPTH = 32;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_A    = 2'd1,
    OWNER_B    = 2'd2
  } owner_t;

  function automatic logic addr_oor(input int unsigned addr, input int unsigned depth);
    return (addr >= depth);
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side bus of the RAM arbiter: command, grant and read-return
// signals for requesters A and B.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    input  b_gnt, b_rvalid, b_rdata, b_err
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    output b_gnt, b_rvalid, b_rdata, b_err
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Round-robin grant decision with bounded bursts: tracks the current owner,
// its consecutive-grant count and the round-robin pointer (0 = A next).
module ram_arb_rr
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  if (MAX_BURST < 1) begin : g_burst_check
    $error("ram_arb_rr: MAX_BURST must be at least 1");
  end

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rr_ptr_q, rr_ptr_d;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      // Contention: owner keeps the bus until its burst budget runs out.
      unique case (owner_q)
        OWNER_A: begin
          a_gnt = (burst_cnt_q < CNT_MAX);
          b_gnt = !(burst_cnt_q < CNT_MAX);
        end
        OWNER_B: begin
          b_gnt = (burst_cnt_q < CNT_MAX);
          a_gnt = !(burst_cnt_q < CNT_MAX);
        end
        default: begin
          a_gnt = !rr_ptr_q;
          b_gnt = rr_ptr_q;
        end
      endcase
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  always_comb begin
    owner_d     = OWNER_NONE;
    burst_cnt_d = '0;
    rr_ptr_d    = rr_ptr_q;
    if (a_gnt) begin
      owner_d     = OWNER_A;
      rr_ptr_d    = 1'b1;
      burst_cnt_d = (owner_q != OWNER_A) ? CNT_W'(1) :
                    (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end else if (b_gnt) begin
      owner_d     = OWNER_B;
      rr_ptr_d    = 1'b0;
      burst_cnt_d = (owner_q != OWNER_B) ? CNT_W'(1) :
                    (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWNER_NONE;
      burst_cnt_q <= '0;
      rr_ptr_q    <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for a 32x8 single-port RAM: RAM port mux,
// held address and read-return pipeline. Optional RAM_ARB_ADDR_CHECK_EN blocks
// out-of-range commands and flags them on a_err/b_err.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arb_if.slave      bus,
  output logic [DW-1:0] ram_data_in,
  output logic [AW-1:0] ram_address,
  output logic          ram_write_enable,
  input  logic [DW-1:0] ram_rdata
);

  if (DEPTH > (1 << AW)) begin : g_depth_check
    $error("ram_arbiter: DEPTH exceeds the address space");
  end

  logic          a_gnt, b_gnt, any_gnt, fwd;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] rdata;

  ram_arb_rr #(.MAX_BURST(MAX_BURST)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  always_comb begin
    any_gnt   = a_gnt | b_gnt;
    sel_we    = b_gnt ? bus.b_we    : bus.a_we;
    sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
    sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
`ifdef RAM_ARB_ADDR_CHECK_EN
    fwd = any_gnt && !addr_oor(32'(sel_addr), DEPTH);
`else
    fwd = any_gnt;
`endif
    ram_write_enable = fwd && sel_we;
    // Idle cycles keep the last forwarded address so the RAM read register is stable.
    ram_address      = fwd ? sel_addr  : addr_hold_q;
    ram_data_in      = fwd ? sel_wdata : '0;
    addr_hold_d      = ram_address;
    a_rvalid_d       = a_gnt && !bus.a_we;
    b_rvalid_d       = b_gnt && !bus.b_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      addr_hold_q <= addr_hold_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end

`ifdef RAM_ARB_ADDR_CHECK_EN
  logic a_err_q, a_err_d;
  logic b_err_q, b_err_d;
  logic rd_zero_q, rd_zero_d;

  always_comb begin
    a_err_d   = a_gnt && !fwd;
    b_err_d   = b_gnt && !fwd;
    rd_zero_d = any_gnt && !fwd && !sel_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  always_comb begin
    rdata       = rd_zero_q ? '0 : ram_rdata;
    bus.a_err   = a_err_q;
    bus.b_err   = b_err_q;
  end
`else
  always_comb begin
    rdata       = ram_rdata;
    bus.a_err   = 1'b0;
    bus.b_err   = 1'b0;
  end
`endif

  always_comb begin
    bus.a_gnt    = a_gnt;
    bus.b_gnt    = b_gnt;
    bus.a_rvalid = a_rvalid_q;
    bus.b_rvalid = b_rvalid_q;
    bus.a_rdata  = rdata;
    bus.b_rdata  = rdata;
  end

endmodule
